// File: rtl/ntt_stream_fifo.sv
// First-word-fall-through token FIFO with a read-only peek port for the NTT butterfly streams.
// Define NTT_FIFO_STATS_EN to add the max_count / drop_count statistics ports.
module ntt_stream_fifo #(
   parameter int DATA_WIDTH = 65,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [DATA_WIDTH-1:0] if_din,
   input  logic                  if_write,
   output logic                  if_full_n,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] peek_dout,
   output logic                  peek_empty_n,
   input  logic                  peek_read
`ifdef NTT_FIFO_STATS_EN
   ,
   output logic [ADDR_WIDTH:0]   max_count,
   output logic [15:0]           drop_count
`endif
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  full_n_q, full_n_d;
   logic                  empty_n_q, empty_n_d;
   logic                  wr_en;
   logic                  rd_en;

   // Peeking is purely observational, so the strobe has no effect on state.
   logic unused_peek_read;
   assign unused_peek_read = peek_read;

   always_comb begin
      wr_en     = if_write && full_n_q;
      rd_en     = if_read && empty_n_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      count_d = count_q + 1'b1;
      else if (rd_en && !wr_en) count_d = count_q - 1'b1;
      empty_n_d = (count_d != '0);
      full_n_d  = (count_d != FULL_COUNT);
   end

   // full_n resets low so nothing is accepted until the first edge after release.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_n_q  <= 1'b0;
         empty_n_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_n_q  <= full_n_d;
         empty_n_q <= empty_n_d;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= if_din;
   end

   assign if_dout      = mem_q[rd_ptr_q];
   assign if_empty_n   = empty_n_q;
   assign if_full_n    = full_n_q;
   assign peek_dout    = mem_q[rd_ptr_q];
   assign peek_empty_n = empty_n_q;

`ifdef NTT_FIFO_STATS_EN
   logic [ADDR_WIDTH:0] max_count_q, max_count_d;
   logic [15:0]         drop_count_q, drop_count_d;

   always_comb begin
      max_count_d  = (count_d > max_count_q) ? count_d : max_count_q;
      drop_count_d = drop_count_q;
      if (if_write && !full_n_q && (drop_count_q != 16'hFFFF))
         drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         max_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         max_count_q  <= max_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign max_count  = max_count_q;
   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_ntt_stream_fifo.sv
// Directed-plus-random bench for ntt_stream_fifo against a queue-based reference model.
// Stats ports are connected and checked only when NTT_FIFO_STATS_EN is defined.
module tb_ntt_stream_fifo;

   localparam int DEPTH = 16;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic [64:0] if_din;
   logic        if_write;
   logic        if_full_n;
   logic [64:0] if_dout;
   logic        if_empty_n;
   logic        if_read;
   logic [64:0] peek_dout;
   logic        peek_empty_n;
   logic        peek_read;
`ifdef NTT_FIFO_STATS_EN
   logic [4:0]  max_count;
   logic [15:0] drop_count;
`endif

   ntt_stream_fifo #(.DATA_WIDTH(65), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .if_din       (if_din),
      .if_write     (if_write),
      .if_full_n    (if_full_n),
      .if_dout      (if_dout),
      .if_empty_n   (if_empty_n),
      .if_read      (if_read),
      .peek_dout    (peek_dout),
      .peek_empty_n (peek_empty_n),
      .peek_read    (peek_read)
`ifdef NTT_FIFO_STATS_EN
      ,
      .max_count    (max_count),
      .drop_count   (drop_count)
`endif
   );

   always #5 ap_clk = ~ap_clk;

   // Reference model: a token queue plus a flag saying the FIFO has seen an edge since reset.
   logic [64:0] model_q[$];
   bit          ready;
   int          exp_max;
   int          exp_drop;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] rand_tok();
      logic [64:0] t;
      t = {1'($urandom), $urandom, $urandom};
      return t;
   endfunction

   task automatic check_outputs();
      chk("empty_n", 65'(if_empty_n), 65'(model_q.size() > 0));
      chk("peek_empty_n", 65'(peek_empty_n), 65'(model_q.size() > 0));
      chk("full_n", 65'(if_full_n), 65'(ready && model_q.size() < DEPTH));
      if (model_q.size() > 0) begin
         chk("dout", if_dout, model_q[0]);
         chk("peek_dout", peek_dout, model_q[0]);
      end
`ifdef NTT_FIFO_STATS_EN
      chk("max_count", 65'(max_count), 65'(exp_max));
      chk("drop_count", 65'(drop_count), 65'(exp_drop));
`endif
   endtask

   // One clock cycle of stimulus; called just after a rising edge.
   task automatic cycle(input logic w, input logic [64:0] d, input logic r, input logic pk);
      bit wa, ra;
      if_write  = w;
      if_din    = d;
      if_read   = r;
      peek_read = pk;
      wa = w && ready && (model_q.size() < DEPTH);
      ra = r && (model_q.size() > 0);
      @(posedge ap_clk);
      if (ra) void'(model_q.pop_front());
      if (wa) model_q.push_back(d);
      if (w && !wa && exp_drop < 16'hFFFF) exp_drop++;
      ready = 1'b1;
      if (model_q.size() > exp_max) exp_max = model_q.size();
      #1;
      $display("txn t=%0t w=%0b din=%h r=%0b pk=%0b acc_w=%0b acc_r=%0b occ=%0d dout=%h",
               $time, w, d, r, pk, wa, ra, model_q.size(), if_dout);
      check_outputs();
      if_write  = 1'b0;
      if_read   = 1'b0;
      peek_read = 1'b0;
   endtask

   task automatic model_reset();
      model_q.delete();
      ready    = 1'b0;
      exp_max  = 0;
      exp_drop = 0;
   endtask

   initial begin
      logic [64:0] tok;
      ap_rst_n  = 1'b0;
      if_din    = '0;
      if_write  = 1'b0;
      if_read   = 1'b0;
      peek_read = 1'b0;
      model_reset();

      // Held in reset: nothing is available and no space is advertised.
      repeat (3) @(posedge ap_clk);
      #1;
      check_outputs();
      ap_rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Two tokens, second carrying EOT, then a pop.
      cycle(1'b1, 65'h0_0000_0000_0000_0001, 1'b0, 1'b0);
      chk("first_head", if_dout, 65'h0_0000_0000_0000_0001);
      cycle(1'b1, 65'h1_0000_0000_0000_0002, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("eot_head", if_dout, 65'h1_0000_0000_0000_0002);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Fill to 16, one rejected write, then simultaneous read+write at full.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_tok(), 1'b0, 1'b0);
      chk("full_after_16", 65'(if_full_n), 65'(0));
      cycle(1'b1, rand_tok(), 1'b0, 1'b0);
      cycle(1'b1, 65'h1_DEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
      chk("full_n_at_15", 65'(if_full_n), 65'(1));
      while (model_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

      // Continuous streaming across two pointer wraps.
      for (int i = 0; i < 40; i++) cycle(1'b1, rand_tok(), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Random mixed traffic.
      for (int i = 0; i < 60; i++)
         cycle(1'($urandom_range(0, 99) < 60), rand_tok(), 1'($urandom_range(0, 99) < 45), 1'($urandom));
      while (model_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

      // Peek strobe never pops.
      for (int i = 0; i < 3; i++) cycle(1'b1, rand_tok(), 1'b0, 1'b0);
      tok = model_q[0];
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      chk("peek_no_pop", if_dout, tok);
      while (model_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset mid-stream with five tokens stored.
      for (int i = 0; i < 5; i++) cycle(1'b1, rand_tok(), 1'b0, 1'b0);
      #2;
      ap_rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);
      tok = rand_tok();
      cycle(1'b1, tok, 1'b0, 1'b0);
      chk("post_reset_head", if_dout, tok);
      cycle(1'b0, '0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
